// File: rtl/gelato_types.sv
// Shared types for the gelato fetch path: warp scheduling state, warp index and PC types.
package gelato_types;

  // Upper bound on warps a scheduler instance may be configured with.
  localparam int unsigned WARP_NUM_MAX     = 32;
  localparam int unsigned PC_WIDTH_DEFAULT = 32;

  // READY: eligible for fetch. WAIT: fetch issued, waiting for the split table to re-enable.
  typedef enum logic {
    READY = 1'b0,
    WAIT  = 1'b1
  } warp_state_t;

  typedef logic [$clog2(WARP_NUM_MAX)-1:0] warp_num_t;
  typedef logic [PC_WIDTH_DEFAULT-1:0]     pc_t;

  // Encode a one-hot warp vector as a warp index (zero when empty).
  function automatic warp_num_t onehot_to_idx(input logic [WARP_NUM_MAX-1:0] oh);
    warp_num_t idx;
    idx = '0;
    for (int i = 0; i < WARP_NUM_MAX; i++) begin
      if (oh[i]) idx = idx | warp_num_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/gelato_rr_arbiter.sv
// Round-robin arbiter: searches upward from one past the last grant, wrapping at N.
// N must be a power of two so the index arithmetic wraps for free.
module gelato_rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic          valid
);

  logic [IW-1:0] idx;

  // First requester found at offsets last+1 .. last+N wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = last + IW'(i);
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gelato_fetch_scheduler.sv
// Warp fetch scheduler: picks one READY warp with a valid PC per cycle (round-robin),
// registers the fetch request, and parks the warp in WAIT until the split table
// re-activates it. Optional performance counters are built when the macro
// GELATO_FETCH_SKD_PERF_EN is defined; otherwise both counters read constant 0.
module gelato_fetch_scheduler
  import gelato_types::*;
#(
  parameter int unsigned WARP_NUM        = 4,
  parameter int unsigned PC_WIDTH        = 32,
  parameter int unsigned SPLIT_NUM_WIDTH = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                rdy,
  input  logic [WARP_NUM-1:0]                 pc_valid,
  input  logic [WARP_NUM*PC_WIDTH-1:0]        pc,
  input  logic [WARP_NUM*SPLIT_NUM_WIDTH-1:0] split_table_num,
  input  logic                                activate_valid,
  input  logic [$clog2(WARP_NUM)-1:0]         activate_warp_num,
  output logic                                fetch_valid,
  input  logic                                fetch_ready,
  output logic [PC_WIDTH-1:0]                 fetch_pc,
  output logic [$clog2(WARP_NUM)-1:0]         fetch_warp_num,
  output logic [SPLIT_NUM_WIDTH-1:0]          fetch_split_table_num,
  output logic [31:0]                         perf_issue_cnt,
  output logic [31:0]                         perf_idle_cnt
);

  localparam int unsigned WW = $clog2(WARP_NUM);

  warp_state_t                warp_state_q [WARP_NUM];
  logic [WW-1:0]              last_grant_q;
  logic                       fetch_valid_q;
  logic [PC_WIDTH-1:0]        fetch_pc_q;
  logic [WW-1:0]              fetch_warp_num_q;
  logic [SPLIT_NUM_WIDTH-1:0] fetch_split_q;

  logic [WARP_NUM-1:0]        eligible;
  logic [WARP_NUM-1:0]        grant;
  logic                       grant_valid;
  logic [WARP_NUM_MAX-1:0]    grant_ext;
  logic [WW-1:0]              grant_idx;
  logic [PC_WIDTH-1:0]        sel_pc;
  logic [SPLIT_NUM_WIDTH-1:0] sel_split;
  logic                       load;

  // Output slot is free or being drained this cycle.
  assign load = rdy && (!fetch_valid_q || fetch_ready);

  // Eligibility uses registered state, so an activate only counts from the next cycle.
  always_comb begin
    for (int w = 0; w < WARP_NUM; w++) begin
      eligible[w] = pc_valid[w] && (warp_state_q[w] == READY);
    end
  end

  gelato_rr_arbiter #(
    .N  (WARP_NUM),
    .IW (WW)
  ) u_rr_arbiter (
    .req   (eligible),
    .last  (last_grant_q),
    .grant (grant),
    .valid (grant_valid)
  );

  // Turn the one-hot grant into an index and select that warp's payload.
  always_comb begin
    grant_ext               = '0;
    grant_ext[WARP_NUM-1:0] = grant;
    grant_idx               = WW'(onehot_to_idx(grant_ext));
    sel_pc                  = pc[int'(grant_idx)*PC_WIDTH +: PC_WIDTH];
    sel_split               = split_table_num[int'(grant_idx)*SPLIT_NUM_WIDTH +: SPLIT_NUM_WIDTH];
  end

  // Warp states, round-robin pointer and the registered fetch request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < WARP_NUM; w++) begin
        warp_state_q[w] <= READY;
      end
      last_grant_q     <= WW'(WARP_NUM - 1);
      fetch_valid_q    <= 1'b0;
      fetch_pc_q       <= '0;
      fetch_warp_num_q <= '0;
      fetch_split_q    <= '0;
    end else if (rdy) begin
      // Activates for READY warps are dropped; a granted warp is always READY,
      // so the two writes below never target the same entry.
      if (activate_valid && (warp_state_q[activate_warp_num] == WAIT)) begin
        warp_state_q[activate_warp_num] <= READY;
      end
      if (load) begin
        fetch_valid_q <= grant_valid;
        if (grant_valid) begin
          warp_state_q[grant_idx] <= WAIT;
          last_grant_q            <= grant_idx;
          fetch_pc_q              <= sel_pc;
          fetch_warp_num_q        <= grant_idx;
          fetch_split_q           <= sel_split;
        end
      end
    end
  end

  assign fetch_valid           = fetch_valid_q;
  assign fetch_pc              = fetch_pc_q;
  assign fetch_warp_num        = fetch_warp_num_q;
  assign fetch_split_table_num = fetch_split_q;

`ifdef GELATO_FETCH_SKD_PERF_EN
  logic [31:0] perf_issue_cnt_q;
  logic [31:0] perf_idle_cnt_q;

  // Handshake and idle-slot counters, frozen with the rest of the state when rdy is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issue_cnt_q <= '0;
      perf_idle_cnt_q  <= '0;
    end else if (rdy) begin
      if (fetch_valid_q && fetch_ready) perf_issue_cnt_q <= perf_issue_cnt_q + 32'd1;
      if (!fetch_valid_q)               perf_idle_cnt_q  <= perf_idle_cnt_q + 32'd1;
    end
  end

  assign perf_issue_cnt = perf_issue_cnt_q;
  assign perf_idle_cnt  = perf_idle_cnt_q;
`else
  assign perf_issue_cnt = '0;
  assign perf_idle_cnt  = '0;
`endif

endmodule
